// File: rtl/onehot_ring_counter.sv
// One-hot ring counter with prescaled stepping, load, and seven-segment readout of the index.
// Optional bounce mode and direction dot are enabled by defining ONEHOT_BOUNCE_EN.
module onehot_ring_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1,
  parameter int unsigned IW    = $clog2(WIDTH)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [IW-1:0]    load_idx,
  output logic [WIDTH-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             dir,
  output logic             wrap,
  output logic [7:0]       seg
);

  localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0]   Last = IW'(WIDTH - 1);
  localparam logic [PW-1:0]   PTop = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] onehot_q;
  logic [7:0]       seg_q;
  logic             step;
  logic             dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign step = en && (presc_q == PTop);

`ifdef ONEHOT_BOUNCE_EN
  logic dir_q, dir_d;
  assign dp_d = dir_d;
  assign dir  = dir_q;
`else
  assign dp_d = 1'b0;
  assign dir  = 1'b0;
`endif

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
`ifdef ONEHOT_BOUNCE_EN
    dir_d   = dir_q;
`endif
    if (load) begin
      presc_d = '0;
      idx_d   = (load_idx > Last) ? Last : load_idx;
`ifdef ONEHOT_BOUNCE_EN
      dir_d   = 1'b0;
`endif
    end else if (en) begin
      presc_d = step ? '0 : presc_q + 1'b1;
      if (step) begin
        case (mode)
          2'b01: begin
            if (idx_q == Last) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          2'b10: begin
            if (idx_q == '0) begin
              idx_d  = Last;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q - 1'b1;
            end
          end
`ifdef ONEHOT_BOUNCE_EN
          2'b11: begin
            // Reversal happens on the step leaving an end, so the ends get no extra dwell
            if (!dir_q) begin
              if (idx_q >= Last) begin
                idx_d  = Last - 1'b1;
                dir_d  = 1'b1;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else begin
              if (idx_q == '0) begin
                idx_d  = IW'(1);
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q - 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
      onehot_q <= One;
      seg_q    <= 8'h3F;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      onehot_q <= One << idx_d;
      seg_q    <= {dp_d, hex7(4'(idx_d))};
    end
  end

`ifdef ONEHOT_BOUNCE_EN
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign onehot = onehot_q;
  assign idx    = idx_q;
  assign wrap   = wrap_q;
  assign seg    = seg_q;

endmodule
